// File: rtl/hwinfo_pkg.sv
// Shared types, AXI response codes and width helpers for the hwinfo_fetch sweep master.
package hwinfo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DEFAULT_REG_DATA_WIDTH = 64;
  localparam int DEFAULT_AXI_DATA_WIDTH = 128;
  localparam int REG_DATA_BYTES         = DEFAULT_REG_DATA_WIDTH / 8;
  localparam int DEFAULT_LANES          = DEFAULT_AXI_DATA_WIDTH / DEFAULT_REG_DATA_WIDTH;

  // Counter width for n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hwinfo_fetch.sv
// AXI4-Lite read-only master: one start pulse sweeps REGNUM info registers into a local cache.
module hwinfo_fetch
  import hwinfo_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 12,
  parameter int C_M_AXI_DATA_WIDTH = DEFAULT_AXI_DATA_WIDTH,
  parameter int REG_DATA_WIDTH     = DEFAULT_REG_DATA_WIDTH,
  parameter int REGNUM             = 16,
  parameter int BASE_ADDR          = 0
) (
  input  logic                                 M_AXI_ACLK_i,
  input  logic                                 M_AXI_ARESET_i,
  input  logic                                 start_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 error_o,
  output logic [REG_DATA_WIDTH*REGNUM-1:0]     regs_o,
  output logic [REGNUM-1:0]                    regs_valid_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_ARADDR_o,
  output logic [2:0]                           M_AXI_ARPROT_o,
  output logic                                 M_AXI_ARVALID_o,
  input  logic                                 M_AXI_ARREADY_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_RDATA_i,
  input  logic [1:0]                           M_AXI_RRESP_i,
  input  logic                                 M_AXI_RVALID_i,
  output logic                                 M_AXI_RREADY_o
);

  localparam int BYTES_PER_REG = REG_DATA_WIDTH / 8;
  localparam int LANES         = C_M_AXI_DATA_WIDTH / REG_DATA_WIDTH;
  localparam int LANE_W        = clog2_min1(LANES);
  localparam int LANE_LSB      = $clog2(BYTES_PER_REG);
  localparam int IDX_W         = clog2_min1(REGNUM);

  typedef logic [C_M_AXI_ADDR_WIDTH-1:0] addr_t;

  localparam addr_t             BASE     = addr_t'(BASE_ADDR);
  localparam addr_t             STRIDE   = addr_t'(BYTES_PER_REG);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(REGNUM - 1);

  state_e                                   state_q, state_d;
  logic [IDX_W-1:0]                         index_q, index_d;
  logic [LANE_W-1:0]                        lane_q, lane_d;
  addr_t                                    araddr_q, araddr_d;
  logic                                     arvalid_q, arvalid_d;
  logic                                     rready_q, rready_d;
  logic                                     busy_q, busy_d;
  logic                                     done_q, done_d;
  logic                                     error_q, error_d;
  logic [REGNUM-1:0][REG_DATA_WIDTH-1:0]    regs_q, regs_d;
  logic [REGNUM-1:0]                        regs_valid_q, regs_valid_d;

  logic [LANES-1:0][REG_DATA_WIDTH-1:0]     rdata_lanes;
  logic [LANE_W-1:0]                        ar_lane;

  assign rdata_lanes = M_AXI_RDATA_i;

  // The lane is taken from the address being presented, so it is already known at the AR handshake.
  generate
    if (LANES > 1) begin : g_multi_lane
      assign ar_lane = araddr_q[LANE_LSB +: LANE_W];
    end else begin : g_single_lane
      assign ar_lane = '0;
    end
  endgenerate

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    index_d      = index_q;
    lane_d       = lane_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    done_d       = 1'b0;
    error_d      = error_q;
    regs_d       = regs_q;
    regs_valid_d = regs_valid_q;

    unique case (state_q)
      IDLE: begin
        // done_q high means the sweep ended on the last edge; a start in that cycle is dropped.
        if (start_i && !done_q) begin
          state_d      = ADDR;
          index_d      = '0;
          araddr_d     = BASE;
          arvalid_d    = 1'b1;
          error_d      = 1'b0;
          regs_valid_d = '0;
        end
      end
      ADDR: begin
        if (M_AXI_ARREADY_i) begin
          state_d   = DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          lane_d    = ar_lane;
        end
      end
      DATA: begin
        if (M_AXI_RVALID_i) begin
          rready_d = 1'b0;
          if (M_AXI_RRESP_i != RESP_OKAY) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            regs_d[index_q]       = rdata_lanes[lane_q];
            regs_valid_d[index_q] = 1'b1;
            if (index_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              index_d   = index_q + 1'b1;
              araddr_d  = araddr_q + STRIDE;
              arvalid_d = 1'b1;
              state_d   = ADDR;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge M_AXI_ACLK_i) begin
    if (M_AXI_ARESET_i) begin
      state_q      <= IDLE;
      index_q      <= '0;
      lane_q       <= '0;
      araddr_q     <= BASE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      // NOTE: the cache is flops, not RAM, so it can be cleared here; consumers never see pre-reset data.
      regs_q       <= '0;
      regs_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      lane_q       <= lane_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      regs_q       <= regs_d;
      regs_valid_q <= regs_valid_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign regs_o          = regs_q;
  assign regs_valid_o    = regs_valid_q;
  assign M_AXI_ARADDR_o  = araddr_q;
  assign M_AXI_ARPROT_o  = 3'b000;
  assign M_AXI_ARVALID_o = arvalid_q;
  assign M_AXI_RREADY_o  = rready_q;

endmodule

// File: tb/tb_hwinfo_fetch.sv
// Bench for hwinfo_fetch: two instances (BASE_ADDR 0 and 8) share one behavioural AXI-Lite slave.
module tb_hwinfo_fetch;
  import hwinfo_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic sel   = 1'b0;

  logic          busy0, done0, err0, arvalid0, rready0;
  logic          busy1, done1, err1, arvalid1, rready1;
  logic [255:0]  regs0, regs1;
  logic [3:0]    rv0, rv1;
  logic [11:0]   araddr0, araddr1;
  logic [2:0]    arprot0, arprot1;

  logic          s_arready = 1'b0;
  logic          s_rvalid  = 1'b0;
  logic [127:0]  s_rdata   = '0;
  logic [1:0]    s_rresp   = '0;

  hwinfo_fetch #(.REGNUM(N), .BASE_ADDR(0)) dut0 (
    .M_AXI_ACLK_i(clk), .M_AXI_ARESET_i(rst), .start_i(start && !sel),
    .busy_o(busy0), .done_o(done0), .error_o(err0), .regs_o(regs0), .regs_valid_o(rv0),
    .M_AXI_ARADDR_o(araddr0), .M_AXI_ARPROT_o(arprot0), .M_AXI_ARVALID_o(arvalid0),
    .M_AXI_ARREADY_i(s_arready && !sel), .M_AXI_RDATA_i(s_rdata), .M_AXI_RRESP_i(s_rresp),
    .M_AXI_RVALID_i(s_rvalid && !sel), .M_AXI_RREADY_o(rready0)
  );

  hwinfo_fetch #(.REGNUM(N), .BASE_ADDR(8)) dut1 (
    .M_AXI_ACLK_i(clk), .M_AXI_ARESET_i(rst), .start_i(start && sel),
    .busy_o(busy1), .done_o(done1), .error_o(err1), .regs_o(regs1), .regs_valid_o(rv1),
    .M_AXI_ARADDR_o(araddr1), .M_AXI_ARPROT_o(arprot1), .M_AXI_ARVALID_o(arvalid1),
    .M_AXI_ARREADY_i(s_arready && sel), .M_AXI_RDATA_i(s_rdata), .M_AXI_RRESP_i(s_rresp),
    .M_AXI_RVALID_i(s_rvalid && sel), .M_AXI_RREADY_o(rready1)
  );

  logic         o_busy, o_done, o_err, o_arvalid, o_rready;
  logic [255:0] o_regs;
  logic [3:0]   o_rv;
  logic [11:0]  o_araddr;
  logic [2:0]   o_arprot;
  assign o_busy    = sel ? busy1    : busy0;
  assign o_done    = sel ? done1    : done0;
  assign o_err     = sel ? err1     : err0;
  assign o_arvalid = sel ? arvalid1 : arvalid0;
  assign o_rready  = sel ? rready1  : rready0;
  assign o_regs    = sel ? regs1    : regs0;
  assign o_rv      = sel ? rv1      : rv0;
  assign o_araddr  = sel ? araddr1  : araddr0;
  assign o_arprot  = sel ? arprot1  : arprot0;

  // Slave configuration, written only by the test sequence.
  int stall_idx = -1;
  int err_idx   = -1;
  int ar_stall  = 5;
  int r_stall   = 7;
  bit lane_mode = 1'b0;

  // Scoreboard queues.
  logic [11:0] exp_addr_q[$];
  logic [11:0] obs_addr_q[$];
  int          exp_idx_q[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int reg_idx(input logic [11:0] a);
    return (int'(a) - (sel ? 8 : 0)) / 8;
  endfunction

  function automatic logic [63:0] exp_val(input int i);
    return 64'hA0 + 64'(i);
  endfunction

  function automatic logic [127:0] beat(input logic [11:0] a);
    logic [63:0] v;
    logic [63:0] g;
    v = exp_val(reg_idx(a));
    g = 64'hBAD0_0000_5A5A_0000 | 64'(reg_idx(a));
    if (!lane_mode) return {v, v};
    return a[3] ? {v, g} : {g, v};
  endfunction

  function automatic int ar_lat(input logic [11:0] a);
    return (reg_idx(a) == stall_idx) ? ar_stall : 1;
  endfunction

  function automatic int r_lat(input int i);
    return (i == stall_idx) ? r_stall : 1;
  endfunction

  function automatic logic [63:0] get_reg(input int i);
    return o_regs[i*64 +: 64];
  endfunction

  // Behavioural AXI-Lite slave: ar_lat cycles of ARVALID before ARREADY, RVALID r_lat cycles after AR.
  int ar_seen = 0;
  int r_cnt   = 0;
  int s_idx   = 0;
  bit s_phase = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_phase   <= 1'b0;
      ar_seen   <= 0;
      r_cnt     <= 0;
    end else if (!s_phase) begin
      if (o_arvalid && s_arready) begin
        s_arready <= 1'b0;
        ar_seen   <= 0;
        obs_addr_q.push_back(o_araddr);
        s_idx     <= reg_idx(o_araddr);
        s_rdata   <= beat(o_araddr);
        s_rresp   <= (reg_idx(o_araddr) == err_idx) ? RESP_SLVERR : RESP_OKAY;
        s_phase   <= 1'b1;
        r_cnt     <= 1;
        if (r_lat(reg_idx(o_araddr)) <= 1) s_rvalid <= 1'b1;
      end else if (o_arvalid) begin
        if (ar_seen + 1 >= ar_lat(o_araddr)) s_arready <= 1'b1;
        ar_seen <= ar_seen + 1;
      end
    end else begin
      if (s_rvalid && o_rready) begin
        s_rvalid <= 1'b0;
        s_phase  <= 1'b0;
        if (s_rresp == RESP_OKAY) exp_idx_q.push_back(s_idx);
      end else if (!s_rvalid) begin
        if (r_cnt + 1 >= r_lat(s_idx)) s_rvalid <= 1'b1;
        r_cnt <= r_cnt + 1;
      end
    end
  end

  // AR stability monitor: once ARVALID is up without ARREADY, it and ARADDR must hold.
  int          stab_viol = 0;
  int          hold16    = 0;
  logic        p_arvalid = 1'b0;
  logic        p_arready = 1'b0;
  logic [11:0] p_araddr  = '0;

  always @(negedge clk) begin
    if (!rst && p_arvalid && !p_arready && (!o_arvalid || o_araddr != p_araddr))
      stab_viol <= stab_viol + 1;
    if (o_arvalid && o_araddr == 12'd16) hold16 <= hold16 + 1;
    p_arvalid <= o_arvalid;
    p_arready <= s_arready;
    p_araddr  <= o_araddr;
  end

  // Results of the last run_sweep call.
  int         done_cyc;
  logic       busy_at_done, busy_before, busy_c1, arvalid_c1, err_c1;
  logic [3:0] rv_c1;

  // Drives one sweep; optional start pulses mid-sweep (cycle mid_at) and coincident with done.
  task automatic run_sweep(input int mid_at, input bit at_done);
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    busy_c1    = o_busy;
    arvalid_c1 = o_arvalid;
    err_c1     = o_err;
    rv_c1      = o_rv;
    busy_before = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) begin
        busy_before = o_busy;
        @(negedge clk);
        start = 1'b0;
      end
      if (o_done) begin
        done_cyc     = c;
        busy_at_done = o_busy;
        if (at_done) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        break;
      end
      if (c == mid_at) start = 1'b1;
    end
  endtask

  task automatic push_addrs(input int base, input int n);
    exp_addr_q.delete();
    obs_addr_q.delete();
    exp_idx_q.delete();
    for (int i = 0; i < n; i++) exp_addr_q.push_back(12'(base + 8 * i));
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (o_arvalid !== 1'b0) $display("FAIL reset_arvalid got %0b want 0", o_arvalid); else n_pass++;
    n_total++; if (o_rready !== 1'b0) $display("FAIL reset_rready got %0b want 0", o_rready); else n_pass++;
    n_total++; if (o_araddr !== 12'd0) $display("FAIL reset_araddr got %0h want 0", o_araddr); else n_pass++;
    n_total++; if (araddr1 !== 12'd8) $display("FAIL reset_araddr_base8 got %0h want 8", araddr1); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", o_busy); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL reset_done got %0b want 0", o_done); else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL reset_error got %0b want 0", o_err); else n_pass++;
    n_total++; if (o_rv !== 4'h0) $display("FAIL reset_regs_valid got %0h want 0", o_rv); else n_pass++;
    n_total++; if (o_regs !== 256'h0) $display("FAIL reset_regs got %0h want 0", o_regs); else n_pass++;
    n_total++; if (o_arprot !== 3'b000) $display("FAIL arprot got %0b want 0", o_arprot); else n_pass++;
  endtask

  // Shared sweep-result comparisons for a clean sweep.
  task automatic test_clean_sweep(input string name, input int base, input int want_done);
    push_addrs(base, N);
    run_sweep(0, 1'b0);
    n_total++; if (done_cyc != want_done) $display("FAIL %s_done_cycle got %0d want %0d", name, done_cyc, want_done); else n_pass++;
    n_total++; if (busy_at_done !== 1'b0 || busy_before !== 1'b1)
      $display("FAIL %s_busy_edge got %0b%0b want 10", name, busy_before, busy_at_done); else n_pass++;
    n_total++; if (busy_c1 !== 1'b1 || arvalid_c1 !== 1'b1)
      $display("FAIL %s_cycle1 got busy %0b arvalid %0b want 1 1", name, busy_c1, arvalid_c1); else n_pass++;
    n_total++; if (o_rv !== 4'hF) $display("FAIL %s_regs_valid got %0h want f", name, o_rv); else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL %s_error got %0b want 0", name, o_err); else n_pass++;
    n_total++; if (obs_addr_q.size() != N) $display("FAIL %s_ar_count got %0d want %0d", name, obs_addr_q.size(), N); else n_pass++;
    while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
      logic [11:0] ea = exp_addr_q.pop_front();
      logic [11:0] oa = obs_addr_q.pop_front();
      n_total++; if (oa !== ea) $display("FAIL %s_araddr got %0h want %0h", name, oa, ea); else n_pass++;
    end
    n_total++; if (exp_idx_q.size() != N) $display("FAIL %s_captures got %0d want %0d", name, exp_idx_q.size(), N); else n_pass++;
    while (exp_idx_q.size() > 0) begin
      int i = exp_idx_q.pop_front();
      n_total++; if (get_reg(i) !== exp_val(i)) $display("FAIL %s_reg%0d got %0h want %0h", name, i, get_reg(i), exp_val(i)); else n_pass++;
    end
  endtask

  task automatic test_basic;
    sel = 1'b0; lane_mode = 1'b0;
    test_clean_sweep("basic", 0, 3 * N + 1);
  endtask

  task automatic test_lane_select;
    sel = 1'b1; lane_mode = 1'b1;
    test_clean_sweep("lane", 8, 3 * N + 1);
    sel = 1'b0; lane_mode = 1'b0;
  endtask

  task automatic test_stall;
    int v0, h0;
    stall_idx = 2;
    v0 = stab_viol;
    h0 = hold16;
    test_clean_sweep("stall", 0, 3 * N + 1 + (ar_stall - 1) + (r_stall - 1));
    n_total++; if (stab_viol - v0 != 0) $display("FAIL stall_ar_stable got %0d violations want 0", stab_viol - v0); else n_pass++;
    n_total++; if (hold16 - h0 != ar_stall + 1) $display("FAIL stall_ar_hold got %0d cycles want %0d", hold16 - h0, ar_stall + 1); else n_pass++;
    stall_idx = -1;
  endtask

  task automatic test_slverr;
    err_idx = 1;
    push_addrs(0, 2);
    run_sweep(0, 1'b0);
    n_total++; if (done_cyc != 7) $display("FAIL err_done_cycle got %0d want 7", done_cyc); else n_pass++;
    n_total++; if (busy_at_done !== 1'b0) $display("FAIL err_busy got %0b want 0", busy_at_done); else n_pass++;
    n_total++; if (o_rv !== 4'b0001) $display("FAIL err_regs_valid got %0b want 0001", o_rv); else n_pass++;
    n_total++; if (o_err !== 1'b1) $display("FAIL err_error got %0b want 1", o_err); else n_pass++;
    n_total++; if (get_reg(1) !== exp_val(1)) $display("FAIL err_reg1_kept got %0h want %0h", get_reg(1), exp_val(1)); else n_pass++;
    while (exp_idx_q.size() > 0) begin
      int i = exp_idx_q.pop_front();
      n_total++; if (i != 0 || get_reg(i) !== exp_val(i)) $display("FAIL err_capture idx %0d got %0h want %0h", i, get_reg(i), exp_val(0)); else n_pass++;
    end
    repeat (10) @(negedge clk);
    n_total++; if (obs_addr_q.size() != 2 || o_arvalid !== 1'b0)
      $display("FAIL err_no_more_ar got %0d reads arvalid %0b want 2 0", obs_addr_q.size(), o_arvalid); else n_pass++;
    n_total++; if (o_err !== 1'b1) $display("FAIL err_sticky got %0b want 1", o_err); else n_pass++;
    err_idx = -1;
  endtask

  task automatic test_start_ignored;
    push_addrs(0, N);
    run_sweep(5, 1'b1);
    n_total++; if (err_c1 !== 1'b0 || rv_c1 !== 4'h0)
      $display("FAIL restart_clear got error %0b valid %0h want 0 0", err_c1, rv_c1); else n_pass++;
    n_total++; if (done_cyc != 3 * N + 1) $display("FAIL ignore_done_cycle got %0d want %0d", done_cyc, 3 * N + 1); else n_pass++;
    repeat (10) @(negedge clk);
    n_total++; if (obs_addr_q.size() != N) $display("FAIL ignore_reads got %0d want %0d", obs_addr_q.size(), N); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL ignore_busy got %0b want 0", o_busy); else n_pass++;
    n_total++; if (o_rv !== 4'hF) $display("FAIL ignore_regs_valid got %0h want f", o_rv); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep;
    bit seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (o_rready) seen = 1'b1;
      else @(negedge clk);
    end
    n_total++; if (!seen) $display("FAIL rst_reach_data got 0 want 1"); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++; if ({o_arvalid, o_rready, o_busy, o_done, o_err} !== 5'b0)
      $display("FAIL rst_mid_ctrl got %05b want 00000", {o_arvalid, o_rready, o_busy, o_done, o_err}); else n_pass++;
    n_total++; if (o_araddr !== 12'd0 || o_rv !== 4'h0 || o_regs !== 256'h0)
      $display("FAIL rst_mid_data got addr %0h valid %0h regs %0h want 0", o_araddr, o_rv, o_regs); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    test_clean_sweep("after_rst", 0, 3 * N + 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lane_select();
    test_stall();
    test_slverr();
    test_start_ignored();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
